maxpool_bank_ctrl: RTL and testbench
====================================

# maxpool_bank_ctrl

Sequencer for the banked single-port feature-map RAM (one bank per channel, shared address) in the first max-pool stage. Loads one IMG_H×IMG_W frame of all-channel pixels from an upstream valid/ready stream, then reads back 2×2 windows and emits one signed max per channel per window to the downstream stream. Drives the bank array's we/ena/addr/din directly and consumes its registered dout (1-cycle read latency).

## Interface
- NUM_RAMS, 128: channels = RAM banks.
- A_WID, 7: bank address width.
- D_WID, 20: signed sample width.
- IMG_W, 8: frame width in pixels; even.
- IMG_H, 8: frame height in pixels; even. IMG_W*IMG_H ≤ 2**A_WID.

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  controller accepts input pixel.
- s_data  in  NUM_RAMS*D_WID  one pixel, channel i at bits [i*D_WID +: D_WID].
- m_valid  out  1  pooled pixel valid.
- m_ready  in  1  downstream accepts pooled pixel.
- m_data  out  NUM_RAMS*D_WID  pooled pixel, same packing.
- frame_done  out  1  one-cycle pulse on the last pooled beat accepted.
- ram_ena  out  NUM_RAMS  bank enables (all bits equal).
- ram_we  out  NUM_RAMS  bank write enables (all bits equal).
- ram_addr  out  A_WID  shared bank address.
- ram_din  out  NUM_RAMS*D_WID  write data (= s_data).
- ram_dout  in  NUM_RAMS*D_WID  bank read data, valid 1 cycle after read enable.

## Operation
- States: LOAD, RD, FIN, OUT.
- LOAD: s_ready=1. On s_valid&&s_ready: ram_ena=ram_we=all-ones, ram_addr=wr_ptr, ram_din=s_data (combinational), wr_ptr++. After beat with wr_ptr=IMG_W*IMG_H-1: wr_ptr←0, go RD with window (pr,pc)=(0,0), rd_idx=0.
- RD: s_ready=0. Base = 2*pr*IMG_W + 2*pc. rd_idx 0..3 issues addr base, base+1, base+IMG_W, base+IMG_W+1; ram_ena=all-ones, ram_we=0. After rd_idx=3 go FIN.
- Compare: data for read k lands the cycle after issue. Read 0 loads acc directly (no compare with stale acc); reads 1..3: acc[i] ← max_signed(acc[i], dout[i]) per channel. Read 3 data consumed in FIN.
- FIN: no RAM access; final compare; go OUT.
- OUT: m_valid=1, m_data=acc (registered, stable while m_valid && !m_ready). On m_ready: advance pc; at pc=IMG_W/2-1 wrap pc←0, pr++. If window was last (pr=IMG_H/2-1, pc=IMG_W/2-1): pulse frame_done, go LOAD; else go RD.
- ram_ena=ram_we=0 whenever no access this cycle; ram_addr holds last value.
- Reset (any time, incl. mid-frame): state LOAD, all counters 0, acc 0; RAM contents not cleared, partial frame discarded.

## Timing
- Reset values: s_ready=1 (after reset deasserts; 0 while rst_n=0 not required—drive 1), m_valid=0, m_data=0, frame_done=0, ram_ena=0, ram_we=0, ram_addr=0, ram_din=s_data.
- Load: one pixel/cycle, IMG_W*IMG_H cycles minimum.
- Per window: 4 RD + 1 FIN cycles, m_valid asserted on 6th cycle after entering RD; with m_ready held high, one pooled pixel every 6 cycles.
- First s_ready after frame_done: cycle following frame_done.
- No input accepted outside LOAD; no output valid outside OUT.

## Configuration
- MAXPOOL_CTRL_RELU_EN defined: m_data channel = (acc<0)?0:acc (ReLU fused at output).
- Undefined: m_data = acc unmodified, negative values pass through.

## Test plan
- Reset mid-RD (NUM_RAMS=2, D_WID=8, IMG 4×4): assert rst_n=0 during window 1 -> m_valid=0, ram_ena=0, s_ready=1; next full frame pools correctly.
- Load ramp ch0=addr, ch1=-addr, 4×4 -> windows ch0 = 5,7,13,15; ch1 = 0,-2,-8,-10 (RELU_EN off) / 0,0,0,0 (on); frame_done once, with 4th acceptance.
- Backpressure: hold m_ready=0 for 10 cycles in OUT -> m_data/m_valid stable, no RAM reads, no counter advance.
- Negative-only window: ch0 values -3,-128,-1,-7 -> output -1 (RELU off), confirms read 0 not compared to acc reset value.
- s_valid gaps: random s_valid duty 50% during LOAD -> exactly 16 writes at addr 0..15 in order, ram_we only on handshake.
- Back-to-back frames: second frame starts cycle after frame_done; outputs match second frame only.

Source files
------------

// File: rtl/maxpool_bank_ctrl_if.sv
// Stream bundle for maxpool_bank_ctrl: pixel input, pooled-pixel output and end-of-frame pulse.
// slave = controller side, master = upstream/downstream environment side.
interface maxpool_bank_ctrl_if #(
  parameter int NUM_RAMS = 128,
  parameter int D_WID    = 20
);
  logic                      s_valid;
  logic                      s_ready;
  logic [NUM_RAMS*D_WID-1:0] s_data;
  logic                      m_valid;
  logic                      m_ready;
  logic [NUM_RAMS*D_WID-1:0] m_data;
  logic                      frame_done;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, frame_done
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, frame_done
  );
endinterface

// File: rtl/maxpool_bank_ctrl.sv
// Banked feature-map RAM sequencer: loads one frame, then emits a signed 2x2 max per channel per window.
// Optional MAXPOOL_CTRL_RELU_EN fuses a ReLU onto the pooled output.
module maxpool_bank_ctrl #(
  parameter int NUM_RAMS = 128,
  parameter int A_WID    = 7,
  parameter int D_WID    = 20,
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  maxpool_bank_ctrl_if.slave        bus,
  output logic [NUM_RAMS-1:0]       ram_ena,
  output logic [NUM_RAMS-1:0]       ram_we,
  output logic [A_WID-1:0]          ram_addr,
  output logic [NUM_RAMS*D_WID-1:0] ram_din,
  input  logic [NUM_RAMS*D_WID-1:0] ram_dout
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int WIN_C = IMG_W / 2;
  localparam int WIN_R = IMG_H / 2;

  typedef enum logic [1:0] {LOAD, RD, FIN, OUT} state_t;

  state_t                   state, state_nx;
  logic [A_WID-1:0]         wr_ptr, pr, pc, addr_q, rd_addr;
  logic [1:0]               rd_idx;
  logic signed [D_WID-1:0]  acc     [NUM_RAMS];
  logic signed [D_WID-1:0]  dout_ch [NUM_RAMS];
  logic                     wr_fire, out_fire, last_pix, last_win;
  logic                     acc_load, acc_cmp;

  assign wr_fire  = (state == LOAD) && bus.s_valid;
  assign out_fire = (state == OUT) && bus.m_ready;
  assign last_pix = (wr_ptr == A_WID'(NPIX - 1));
  assign last_win = (pr == A_WID'(WIN_R - 1)) && (pc == A_WID'(WIN_C - 1));

  assign bus.s_ready = (state == LOAD);
  assign bus.m_valid = (state == OUT);
  assign ram_din     = bus.s_data;

  // rd_idx bit 1 selects the lower row of the window, bit 0 the right column
  always_comb begin
    rd_addr = A_WID'(2 * IMG_W) * pr + (pc << 1)
            + (rd_idx[1] ? A_WID'(IMG_W) : '0) + A_WID'(rd_idx[0]);
  end

  always_comb begin
    state_nx       = state;
    ram_ena        = '0;
    ram_we         = '0;
    ram_addr       = addr_q;
    bus.frame_done = 1'b0;
    unique case (state)
      LOAD: if (bus.s_valid) begin
        ram_ena  = '1;
        ram_we   = '1;
        ram_addr = wr_ptr;
        if (last_pix) state_nx = RD;
      end
      RD: begin
        ram_ena  = '1;
        ram_addr = rd_addr;
        if (rd_idx == 2'd3) state_nx = FIN;
      end
      FIN: state_nx = OUT;
      OUT: if (bus.m_ready) begin
        bus.frame_done = last_win;
        state_nx       = last_win ? LOAD : RD;
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LOAD;
      wr_ptr <= '0;
      pr     <= '0;
      pc     <= '0;
      rd_idx <= '0;
      addr_q <= '0;
    end else begin
      state  <= state_nx;
      addr_q <= ram_addr;
      if (wr_fire) wr_ptr <= last_pix ? '0 : wr_ptr + A_WID'(1);
      if (state == RD) rd_idx <= rd_idx + 2'd1;
      if (out_fire) begin
        if (pc == A_WID'(WIN_C - 1)) begin
          pc <= '0;
          pr <= last_win ? '0 : pr + A_WID'(1);
        end else begin
          pc <= pc + A_WID'(1);
        end
      end
    end
  end

  // Read data trails its issue by one cycle, so the first sample of a window arrives at rd_idx==1
  assign acc_load = (state == RD) && (rd_idx == 2'd1);
  assign acc_cmp  = ((state == RD) && (rd_idx > 2'd1)) || (state == FIN);

  always_comb begin
    for (int unsigned i = 0; i < NUM_RAMS; i++)
      dout_ch[i] = $signed(ram_dout[i*D_WID +: D_WID]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_RAMS; i++) acc[i] <= '0;
    end else if (acc_load) begin
      for (int unsigned i = 0; i < NUM_RAMS; i++) acc[i] <= dout_ch[i];
    end else if (acc_cmp) begin
      for (int unsigned i = 0; i < NUM_RAMS; i++)
        if (dout_ch[i] > acc[i]) acc[i] <= dout_ch[i];
    end
  end

  always_comb begin
    bus.m_data = '0;
    for (int unsigned i = 0; i < NUM_RAMS; i++) begin
`ifdef MAXPOOL_CTRL_RELU_EN
      bus.m_data[i*D_WID +: D_WID] = acc[i][D_WID-1] ? '0 : acc[i];
`else
      bus.m_data[i*D_WID +: D_WID] = acc[i];
`endif
    end
  end

endmodule

// File: tb/tb_maxpool_bank_ctrl.sv
// Directed bench for maxpool_bank_ctrl on a 2-channel, 8-bit, 4x4 frame with a behavioural bank array.
module tb_maxpool_bank_ctrl;
  localparam int NR = 2;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int W  = 4;
  localparam int H  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    ram_ena, ram_we;
  logic [AW-1:0]    ram_addr;
  logic [NR*DW-1:0] ram_din, ram_dout;

  maxpool_bank_ctrl_if #(.NUM_RAMS(NR), .D_WID(DW)) bus ();

  maxpool_bank_ctrl #(
    .NUM_RAMS(NR), .A_WID(AW), .D_WID(DW), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ram_ena(ram_ena), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  logic [15:0] mem [16];
  always @(posedge clk) begin
    if (ram_ena[0]) begin
      if (ram_we[0]) mem[ram_addr] <= ram_din;
      else           ram_dout      <= mem[ram_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] ramp [16];
  logic [15:0] f2   [16];
  logic [7:0]  f2c0 [16] = '{8'hFD, 8'h80, 8'd100, 8'hCE, 8'hFF, 8'hF9, 8'd20, 8'd99,
                             8'h9C, 8'h9C, 8'h00,  8'hFF, 8'h9C, 8'h9D, 8'hFE, 8'hFD};
  logic [7:0]  exp_r0 [4] = '{8'd5, 8'd7, 8'd13, 8'd15};
  logic [7:0]  exp_f1 [4] = '{8'h0F, 8'h15, 8'h27, 8'h2D};
`ifdef MAXPOOL_CTRL_RELU_EN
  logic [7:0]  exp_r1 [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0]  exp_f0 [4] = '{8'h00, 8'h64, 8'h00, 8'h00};
`else
  logic [7:0]  exp_r1 [4] = '{8'h00, 8'hFE, 8'hF8, 8'hF6};
  logic [7:0]  exp_f0 [4] = '{8'hFF, 8'h64, 8'h9D, 8'h00};
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input logic [15:0] px [16], input bit gaps);
    int unsigned n = 0;
    int unsigned cyc = 0;
    while (n < 16 && cyc < 200) begin
      @(negedge clk);
      bus.s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_data  = px[n];
      #1;
      chk("ld_sready", bus.s_ready, 1);
      chk("ld_mvalid", bus.m_valid, 0);
      if (bus.s_valid) begin
        chk("ld_we",   ram_we,   2'b11);
        chk("ld_ena",  ram_ena,  2'b11);
        chk("ld_addr", ram_addr, n);
        chk("ld_din",  ram_din,  px[n]);
        n++;
      end else begin
        chk("ld_idle_we",  ram_we,  0);
        chk("ld_idle_ena", ram_ena, 0);
      end
      cyc++;
    end
    chk("ld_count", n, 16);
  endtask

  task automatic get_window(input int unsigned w, input logic [7:0] e0, input logic [7:0] e1,
                            input int unsigned bp, input bit last);
    int unsigned c = 0;
    logic [3:0]  base = 4'((w / 2) * 2 * W + (w % 2) * 2);
    logic [3:0]  offs [4] = '{4'd0, 4'd1, 4'd4, 4'd5};
    logic [15:0] held;
    bus.m_ready = 1'b0;
    do begin
      @(negedge clk);
      bus.s_valid = 1'b0;
      #1;
      c++;
      if (c <= 4) begin
        chk("rd_ena",    ram_ena,  2'b11);
        chk("rd_we",     ram_we,   0);
        chk("rd_addr",   ram_addr, 4'(base + offs[c-1]));
        chk("rd_sready", bus.s_ready, 0);
      end else if (!bus.m_valid) begin
        chk("fin_ena", ram_ena, 0);
      end
    end while (!bus.m_valid && c < 20);
    chk("latency",  c, 6);
    chk("m_ch0",    bus.m_data[7:0],  e0);
    chk("m_ch1",    bus.m_data[15:8], e1);
    chk("fd_idle",  bus.frame_done, 0);
    held = bus.m_data;
    repeat (bp) begin
      @(negedge clk);
      #1;
      chk("bp_valid", bus.m_valid, 1);
      chk("bp_data",  bus.m_data,  held);
      chk("bp_ena",   ram_ena,     0);
    end
    bus.m_ready = 1'b1;
    #1;
    chk("frame_done", bus.frame_done, last);
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
  endtask

  task automatic get_frame(input logic [7:0] e0 [4], input logic [7:0] e1 [4], input int unsigned bp);
    for (int unsigned w = 0; w < 4; w++)
      get_window(w, e0[w], e1[w], (w == 0) ? bp : 0, w == 3);
  endtask

  initial begin
    for (int a = 0; a < 16; a++) begin
      ramp[a] = {8'(-a), 8'(a)};
      f2[a]   = {8'(3 * a), f2c0[a]};
    end
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_sready", bus.s_ready, 1);
    chk("rst_mvalid", bus.m_valid, 0);
    chk("rst_mdata",  bus.m_data,  0);
    chk("rst_fd",     bus.frame_done, 0);
    chk("rst_ena",    ram_ena, 0);
    chk("rst_we",     ram_we,  0);
    chk("rst_addr",   ram_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp with random s_valid gaps and backpressure on the first window
    load_frame(ramp, 1'b1);
    get_frame(exp_r0, exp_r1, 10);

    // Second frame starts the cycle after frame_done; includes the all-negative window
    load_frame(f2, 1'b0);
    get_frame(exp_f0, exp_f1, 0);

    // Reset in the middle of window 1 reads, then a clean frame
    load_frame(ramp, 1'b0);
    get_window(0, exp_r0[0], exp_r1[0], 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mvalid", bus.m_valid, 0);
    chk("mid_rst_ena",    ram_ena, 0);
    chk("mid_rst_we",     ram_we,  0);
    chk("mid_rst_sready", bus.s_ready, 1);
    chk("mid_rst_mdata",  bus.m_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    load_frame(ramp, 1'b1);
    get_frame(exp_r0, exp_r1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
